// File: rtl/uart_apb_fifo.sv
// APB-attached UART with parametrised character width, TX/RX FIFOs, programmable
// baud divisor, sticky error flags and a registered level interrupt.

module uart_apb_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end
endmodule

module uart_apb_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [3:0]  in_paddr,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    input  logic [2:0]  in_pprot,
    output logic [31:0] in_prdata,
    output logic        in_pready,
    output logic        in_pslverr,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic                 apb_access;
    logic                 apb_wr;
    logic                 apb_rd;
    logic [1:0]           reg_sel;
    logic                 unused_apb;

    logic [DIV_W-1:0]     div_reg;
    logic [DIV_W-1:0]     div_wr_val;
    logic [4:0]           ctrl_reg;
    logic                 overrun_reg;
    logic                 frame_err_reg;
    logic                 irq_reg;
    logic                 irq_next;
    logic                 status_wr;
    logic                 tx_en;
    logic                 rx_en;

    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_push;
    logic                 rx_pop;
    logic [DATA_BITS-1:0] rx_head;

    uart_state_t          tx_state_reg, tx_state_next;
    logic [DIV_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_out_reg, tx_out_next;
    logic                 tx_busy;

    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic                 rx_fall;
    uart_state_t          rx_state_reg, rx_state_next;
    logic [DIV_W-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_overrun_set;
    logic                 rx_frame_set;

    assign apb_access = in_psel & in_penable;
    assign apb_wr     = apb_access & in_pwrite & in_pstrb[0];
    assign apb_rd     = apb_access & ~in_pwrite;
    assign reg_sel    = in_paddr[3:2];
    assign unused_apb = ^{in_pprot, in_pstrb[3:1], in_paddr[1:0], in_pwdata};
    assign in_pready  = 1'b1;

    assign tx_en     = ctrl_reg[0];
    assign rx_en     = ctrl_reg[1];
    assign tx_busy   = (tx_state_reg != ST_IDLE);
    assign status_wr = apb_wr & (reg_sel == ADDR_STATUS);
    assign tx_push   = apb_wr & (reg_sel == ADDR_DATA);
    assign rx_pop    = apb_rd & (reg_sel == ADDR_DATA) & ~rx_empty;
    assign div_wr_val = (in_pwdata[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : in_pwdata[DIV_W-1:0];

    uart_apb_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .wdata  (in_pwdata[DATA_BITS-1:0]),
        .pop    (tx_pop),
        .rdata  (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    uart_apb_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .wdata  (rx_shift_reg),
        .pop    (rx_pop),
        .rdata  (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_comb begin
        in_prdata  = '0;
        in_pslverr = 1'b0;
        if (apb_rd) begin
            case (reg_sel)
                ADDR_DATA: begin
                    if (rx_empty) begin
                        in_pslverr = 1'b1;
                    end else begin
                        in_prdata = 32'(rx_head);
                    end
                end
                ADDR_STATUS: in_prdata = {25'd0, tx_busy, frame_err_reg, overrun_reg,
                                          rx_empty, rx_full, tx_empty, tx_full};
                ADDR_DIV:    in_prdata = 32'(div_reg);
                default:     in_prdata = 32'(ctrl_reg);
            endcase
        end
        if (tx_push && tx_full && !tx_pop) begin
            in_pslverr = 1'b1;
        end
    end

    assign irq_next = (ctrl_reg[2] & ~rx_empty) | (ctrl_reg[3] & tx_empty) |
                      (ctrl_reg[4] & (overrun_reg | frame_err_reg));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_reg       <= DIV_W'(DIV_RESET);
            ctrl_reg      <= 5'h03;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            if (apb_wr && reg_sel == ADDR_DIV) begin
                div_reg <= div_wr_val;
            end
            if (apb_wr && reg_sel == ADDR_CTRL) begin
                ctrl_reg <= in_pwdata[4:0];
            end
            // New error events take priority over a write-1-to-clear in the same cycle.
            overrun_reg   <= rx_overrun_set | (overrun_reg & ~(status_wr & in_pwdata[4]));
            frame_err_reg <= rx_frame_set | (frame_err_reg & ~(status_wr & in_pwdata[5]));
            irq_reg       <= irq_next;
        end
    end

    assign irq = irq_reg;

    // Transmitter: counters reload from div_reg at every bit boundary.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_out_next   = tx_out_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            ST_IDLE: begin
                tx_out_next = 1'b1;
                if (tx_en && !tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = ST_START;
                    tx_out_next   = 1'b0;
                    tx_cnt_next   = div_reg - DIV_W'(1);
                    tx_shift_next = tx_head;
                end
            end
            ST_START: begin
                if (tx_cnt_reg == '0) begin
                    tx_state_next = ST_DATA;
                    tx_out_next   = tx_shift_reg[0];
                    tx_cnt_next   = div_reg - DIV_W'(1);
                    tx_bit_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next = div_reg - DIV_W'(1);
                    if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
                        tx_state_next = ST_STOP;
                        tx_out_next   = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'(1);
                        tx_out_next   = tx_shift_reg[1];
                        tx_shift_next = tx_shift_reg >> 1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - DIV_W'(1);
                end
            end
            default: begin
                if (tx_cnt_reg == '0) begin
                    if (tx_en && !tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_state_next = ST_START;
                        tx_out_next   = 1'b0;
                        tx_cnt_next   = div_reg - DIV_W'(1);
                        tx_shift_next = tx_head;
                    end else begin
                        tx_state_next = ST_IDLE;
                        tx_out_next   = 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_out_reg   <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_out_reg   <= tx_out_next;
        end
    end

    assign uart_tx = tx_out_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign rx_fall = rx_prev_reg & ~rx_sync_reg;

    // Receiver: start bit checked at half a bit, then one sample per bit period.
    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        rx_push        = 1'b0;
        rx_overrun_set = 1'b0;
        rx_frame_set   = 1'b0;
        case (rx_state_reg)
            ST_IDLE: begin
                if (rx_en && rx_fall) begin
                    rx_state_next = ST_START;
                    rx_cnt_next   = (div_reg >> 1) - DIV_W'(1);
                end
            end
            ST_START: begin
                if (rx_cnt_reg == '0) begin
                    if (rx_sync_reg) begin
                        rx_state_next = ST_IDLE;
                    end else begin
                        rx_state_next = ST_DATA;
                        rx_cnt_next   = div_reg - DIV_W'(1);
                        rx_bit_next   = '0;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    rx_cnt_next   = div_reg - DIV_W'(1);
                    if (rx_bit_reg == 3'(DATA_BITS - 1)) begin
                        rx_state_next = ST_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'(1);
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - DIV_W'(1);
                end
            end
            default: begin
                if (rx_cnt_reg == '0) begin
                    rx_state_next = ST_IDLE;
                    if (!rx_sync_reg) begin
                        rx_frame_set = 1'b1;
                    end else if (rx_full && !rx_pop) begin
                        rx_overrun_set = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end
endmodule

// File: tb/tb_uart_apb_fifo.sv
// Scoreboard bench for uart_apb_fifo: stimulus queues expected APB responses and
// TX frames; independent monitors pop and compare when the DUT produces them.

module tb_uart_apb_fifo;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        is_read;
    } apb_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       gap;
    } tx_exp_t;

    apb_exp_t   apb_q[$];
    string      apb_name_q[$];
    tx_exp_t    tx_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         tb_div = 434;
    logic [7:0] rx_chars [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    uart_apb_fifo dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_psel    (psel),
        .in_penable (penable),
        .in_pwrite  (pwrite),
        .in_paddr   (paddr),
        .in_pwdata  (pwdata),
        .in_pstrb   (pstrb),
        .in_pprot   (pprot),
        .in_prdata  (prdata),
        .in_pready  (pready),
        .in_pslverr (pslverr),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input string name, input logic [3:0] addr, input logic [31:0] data,
                             input logic exp_err);
        apb_exp_t e;
        e.data = '0; e.err = exp_err; e.is_read = 1'b0;
        apb_q.push_back(e);
        apb_name_q.push_back(name);
        apb_xfer(1'b1, addr, data);
    endtask

    task automatic apb_read(input string name, input logic [3:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
        apb_exp_t e;
        e.data = exp_data; e.err = exp_err; e.is_read = 1'b1;
        apb_q.push_back(e);
        apb_name_q.push_back(name);
        apb_xfer(1'b0, addr, 32'h0);
    endtask

    task automatic expect_tx(input logic [7:0] data, input logic gap);
        tx_exp_t e;
        e.data = data; e.gap = gap;
        tx_q.push_back(e);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        @(posedge clk); #1;
        for (int b = 0; b < 10; b++) begin
            uart_rx = f[b];
            repeat (tb_div) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic check_irq(input string name, input logic exp);
        repeat (2) @(posedge clk);
        #1;
        check(name, 32'(irq), 32'(exp));
    endtask

    initial begin : apb_monitor
        apb_exp_t e;
        string    n;
        forever begin
            @(negedge clk);
            if (psel === 1'b1 && penable === 1'b1) begin
                if (apb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL apb_unexpected: access to 0x%0h seen, none expected", paddr);
                end else begin
                    e = apb_q.pop_front();
                    n = apb_name_q.pop_front();
                    if (e.is_read) check(n, prdata, e.data);
                    check({n, "_pslverr"}, 32'(pslverr), 32'(e.err));
                end
            end
        end
    end

    initial begin : tx_monitor
        logic [9:0] bits;
        logic       stable;
        int         start_cyc;
        int         prev_start;
        int         span;
        bit         have_prev;
        tx_exp_t    e;
        have_prev  = 1'b0;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                start_cyc = cyc;
                span      = 10 * tb_div;
                stable    = 1'b1;
                bits      = '0;
                for (int i = 0; i < span; i++) begin
                    if (i > 0) @(negedge clk);
                    if (i % tb_div == 0) bits[i / tb_div] = uart_tx;
                    else if (uart_tx !== bits[i / tb_div]) stable = 1'b0;
                end
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: frame %b seen, none expected", bits);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_frame", 32'(bits), 32'({1'b1, e.data, 1'b0}));
                    check("tx_bit_timing", 32'(stable), 32'd1);
                    if (e.gap && have_prev) check("tx_b2b_gap", 32'(start_cyc - prev_start), 32'(span));
                end
                have_prev  = 1'b1;
                prev_start = start_cyc;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int waited;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", 32'(pready), 32'd1);
        resetn = 1'b1;
        apb_read("rst_status", 4'h4, 32'h0A, 1'b0);
        apb_read("rst_ctrl", 4'hC, 32'h03, 1'b0);
        apb_read("rst_div", 4'h8, 32'd434, 1'b0);

        apb_write("div_wr_small", 4'h8, 32'd2, 1'b0);
        apb_read("div_clamped", 4'h8, 32'd4, 1'b0);
        tb_div = 8;
        apb_write("div_wr_8", 4'h8, 32'd8, 1'b0);

        // single frame
        expect_tx(8'hA5, 1'b0);
        apb_write("tx_a5", 4'h0, 32'h0000_00A5, 1'b0);
        repeat (100) @(posedge clk);
        apb_read("status_tx_done", 4'h4, 32'h0A, 1'b0);

        // FIFO fill while first frame is on the wire; sixth write overflows
        expect_tx(8'h01, 1'b0);
        apb_write("tx_q1", 4'h0, 32'hFFFF_FF01, 1'b0);
        expect_tx(8'h80, 1'b1);
        apb_write("tx_q2", 4'h0, 32'h80, 1'b0);
        expect_tx(8'hFF, 1'b1);
        apb_write("tx_q3", 4'h0, 32'hFF, 1'b0);
        expect_tx(8'h00, 1'b1);
        apb_write("tx_q4", 4'h0, 32'h00, 1'b0);
        expect_tx(8'h5A, 1'b1);
        apb_write("tx_q5", 4'h0, 32'h5A, 1'b0);
        apb_write("tx_q6_full", 4'h0, 32'h77, 1'b1);
        repeat (440) @(posedge clk);
        apb_read("status_tx_drained", 4'h4, 32'h0A, 1'b0);

        // receive with RX-not-empty interrupt
        tb_div = 16;
        apb_write("div_wr_16", 4'h8, 32'd16, 1'b0);
        apb_write("ctrl_rxne", 4'hC, 32'h07, 1'b0);
        send_rx(8'h3C, 1'b1);
        check_irq("irq_rxne_set", 1'b1);
        apb_read("rx_3c", 4'h0, 32'h3C, 1'b0);
        apb_read("status_rx_empty", 4'h4, 32'h0A, 1'b0);
        check_irq("irq_rxne_drop", 1'b0);

        // overrun: five characters into a four-entry FIFO
        apb_write("ctrl_plain", 4'hC, 32'h03, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_rx(rx_chars[i], 1'b1);
            repeat (4) @(posedge clk);
        end
        apb_read("status_overrun", 4'h4, 32'h16, 1'b0);
        apb_write("ctrl_errie", 4'hC, 32'h13, 1'b0);
        check_irq("irq_err_set", 1'b1);
        for (int i = 0; i < 4; i++) begin
            apb_read("rx_fifo_rd", 4'h0, 32'(rx_chars[i]), 1'b0);
        end
        apb_read("status_rx_drained", 4'h4, 32'h1A, 1'b0);
        apb_read("rx_empty_rd", 4'h0, 32'h0, 1'b1);
        apb_write("clr_overrun", 4'h4, 32'h10, 1'b0);
        apb_read("status_ovr_clr", 4'h4, 32'h0A, 1'b0);
        check_irq("irq_err_drop", 1'b0);
        apb_write("ctrl_plain2", 4'hC, 32'h03, 1'b0);

        // framing error and start-bit glitch
        send_rx(8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        apb_read("status_frame_err", 4'h4, 32'h2A, 1'b0);
        apb_write("clr_frame_err", 4'h4, 32'h20, 1'b0);
        apb_read("status_ferr_clr", 4'h4, 32'h0A, 1'b0);
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        apb_read("status_glitch", 4'h4, 32'h0A, 1'b0);

        waited = 0;
        while ((apb_q.size() != 0 || tx_q.size() != 0) && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        check("drain_pending", 32'(apb_q.size() + tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
